// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the cache miss-fill path.
//   - Default geometry (DEF_*) used as parameter defaults by cache_fill_ctrl.
//   - Widths derived from the defaults (set/way index, line, beat, beat count).
//   - clog2_min1(): ceil(log2(n)) but never less than 1, so that a geometry
//     with a single set/way/beat still gets a 1-bit index.
//   - fill_state_t: the miss-fill FSM state encoding.
// -----------------------------------------------------------------------------
package cache_pkg;

    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    localparam int DEF_NUM_WAYS             = 4;
    localparam int DEF_NUM_SETS             = 16;
    localparam int DEF_CACHE_LINE_TAG_WIDTH = 22;
    localparam int DEF_CACHE_LINE_BYTES     = 64;
    localparam int DEF_L2_BEAT_BYTES        = 16;

    localparam int NUM_SETS_LOG    = clog2_min1(DEF_NUM_SETS);
    localparam int NUM_WAYS_LOG    = clog2_min1(DEF_NUM_WAYS);
    localparam int CACHE_LINE_BITS = DEF_CACHE_LINE_BYTES * 8;
    localparam int BEAT_BITS       = DEF_L2_BEAT_BYTES * 8;
    localparam int NUM_BEATS       = DEF_CACHE_LINE_BYTES / DEF_L2_BEAT_BYTES;
    localparam int BEAT_CNT_W      = clog2_min1(NUM_BEATS);

    typedef enum logic [2:0] {
        FILL_IDLE     = 3'd0,
        FILL_LRU      = 3'd1,
        FILL_LRU_WAIT = 3'd2,
        FILL_REQ      = 3'd3,
        FILL_BEAT     = 3'd4,
        FILL_WRITE    = 3'd5
    } fill_state_t;

endpackage

// File: rtl/cache_fill_beat_asm.sv
// -----------------------------------------------------------------------------
// cache_fill_beat_asm
// Beat counter plus line assembly register for an L2 line fill.
// Each cycle with beat_en, beat_data is stored in slot <count> and the counter
// advances; the beat that fills the last slot raises line_complete (combinational,
// same cycle) and wraps the counter to 0, so the next fill starts at slot 0.
// Ports:
//   clk, rst       clock, asynchronous active-high reset (clears counter and line)
//   beat_en        accept beat_data this cycle
//   beat_data      one L2 response beat
//   line           assembled line, beat i at bits [i*BEAT_BITS +: BEAT_BITS]
//   line_complete  this beat is the last of the line
// -----------------------------------------------------------------------------
module cache_fill_beat_asm #(
    parameter int  BEAT_BITS = 128,
    parameter int  NUM_BEATS = 4,
    localparam int CNT_W     = (NUM_BEATS <= 1) ? 1 : $clog2(NUM_BEATS),
    localparam int LINE_BITS = BEAT_BITS * NUM_BEATS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 beat_en,
    input  logic [BEAT_BITS-1:0] beat_data,
    output logic [LINE_BITS-1:0] line,
    output logic                 line_complete
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    logic [CNT_W-1:0]     count_reg;
    logic [BEAT_BITS-1:0] beat_reg [NUM_BEATS];

    assign line_complete = beat_en && (count_reg == LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (beat_en) begin
            count_reg <= line_complete ? '0 : count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BEATS; i++) begin
                beat_reg[i] <= '0;
            end
        end else if (beat_en) begin
            for (int i = 0; i < NUM_BEATS; i++) begin
                if (count_reg == CNT_W'(i)) begin
                    beat_reg[i] <= beat_data;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BEATS; gi++) begin : g_line
            assign line[gi*BEAT_BITS +: BEAT_BITS] = beat_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/cache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_fill_ctrl
// Miss-fill engine for the cache update side. Accepts one miss (set, tag),
// queries the LRU for a victim way, fetches the line from L2 as NUM_BEATS beats
// and writes tag + data into the victim way in one cycle, with a fill_done pulse.
// FSM: IDLE -> LRU -> LRU_WAIT -> REQ -> BEAT -> WRITE -> IDLE.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   miss_valid/ready/set_idx/tag   miss request handshake (ready only in IDLE)
//   lru_fill_en/set, lru_fill_way_idx
//                                  victim query; way is valid the cycle after en
//   l2_req_valid/ready/addr        line request, addr = {tag, set}
//   l2_rsp_valid/data              response beats, no back-pressure
//   update_tag_*, update_data_*    tag/data write strobes (WRITE cycle)
//   fill_done, fill_done_set_idx/way_idx
//                                  one-cycle completion pulse
// Optional build macro CACHE_FILL_PERF_EN adds saturating counters:
//   perf_fill_count      completed fills
//   perf_l2_wait_cycles  cycles spent in REQ or BEAT
// -----------------------------------------------------------------------------
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int  NUM_WAYS             = DEF_NUM_WAYS,
    parameter int  NUM_SETS             = DEF_NUM_SETS,
    parameter int  CACHE_LINE_TAG_WIDTH = DEF_CACHE_LINE_TAG_WIDTH,
    parameter int  CACHE_LINE_BYTES     = DEF_CACHE_LINE_BYTES,
    parameter int  L2_BEAT_BYTES        = DEF_L2_BEAT_BYTES,
    localparam int SET_W  = clog2_min1(NUM_SETS),
    localparam int WAY_W  = clog2_min1(NUM_WAYS),
    localparam int TAG_W  = CACHE_LINE_TAG_WIDTH,
    localparam int LINE_W = CACHE_LINE_BYTES * 8,
    localparam int BEAT_W = L2_BEAT_BYTES * 8,
    localparam int BEATS  = CACHE_LINE_BYTES / L2_BEAT_BYTES
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               miss_valid,
    output logic               miss_ready,
    input  logic [SET_W-1:0]   miss_set_idx,
    input  logic [TAG_W-1:0]   miss_tag,

    output logic               lru_fill_en,
    output logic [SET_W-1:0]   lru_fill_set,
    input  logic [WAY_W-1:0]   lru_fill_way_idx,

    output logic               l2_req_valid,
    input  logic               l2_req_ready,
    output logic [TAG_W+SET_W-1:0] l2_req_addr,

    input  logic               l2_rsp_valid,
    input  logic [BEAT_W-1:0]  l2_rsp_data,

    output logic               update_tag_en,
    output logic [WAY_W-1:0]   update_tag_way_idx,
    output logic [SET_W-1:0]   update_tag_set_idx,
    output logic [TAG_W-1:0]   update_tag,
    output logic               update_tag_valid,

    output logic               update_data_en,
    output logic [WAY_W-1:0]   update_data_way_idx,
    output logic [SET_W-1:0]   update_data_set_idx,
    output logic [LINE_W-1:0]  update_data,

    output logic               fill_done,
    output logic [SET_W-1:0]   fill_done_set_idx,
    output logic [WAY_W-1:0]   fill_done_way_idx
`ifdef CACHE_FILL_PERF_EN
    ,
    output logic [31:0]        perf_fill_count,
    output logic [31:0]        perf_l2_wait_cycles
`endif
);

    fill_state_t state_reg, state_next;

    logic [SET_W-1:0]  set_reg;
    logic [TAG_W-1:0]  tag_reg;
    logic [WAY_W-1:0]  way_reg;

    logic              beat_en;
    logic              line_complete;
    logic [LINE_W-1:0] line;
    logic              write_cycle;

    // Beats arriving outside BEAT are dropped here, so a stray response can
    // neither advance the counter nor corrupt the assembled line.
    assign beat_en = (state_reg == FILL_BEAT) && l2_rsp_valid;

    cache_fill_beat_asm #(
        .BEAT_BITS (BEAT_W),
        .NUM_BEATS (BEATS)
    ) u_beat_asm (
        .clk           (clk),
        .rst           (rst),
        .beat_en       (beat_en),
        .beat_data     (l2_rsp_data),
        .line          (line),
        .line_complete (line_complete)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= FILL_IDLE;
            set_reg   <= '0;
            tag_reg   <= '0;
            way_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == FILL_IDLE && miss_valid) begin
                set_reg <= miss_set_idx;
                tag_reg <= miss_tag;
            end
            // The LRU answers one cycle after lru_fill_en, i.e. during LRU_WAIT.
            if (state_reg == FILL_LRU_WAIT) begin
                way_reg <= lru_fill_way_idx;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        miss_ready   = 1'b0;
        lru_fill_en  = 1'b0;
        l2_req_valid = 1'b0;
        write_cycle  = 1'b0;
        case (state_reg)
            FILL_IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) begin
                    state_next = FILL_LRU;
                end
            end
            FILL_LRU: begin
                lru_fill_en = 1'b1;
                state_next  = FILL_LRU_WAIT;
            end
            FILL_LRU_WAIT: begin
                state_next = FILL_REQ;
            end
            FILL_REQ: begin
                l2_req_valid = 1'b1;
                if (l2_req_ready) begin
                    state_next = FILL_BEAT;
                end
            end
            FILL_BEAT: begin
                if (line_complete) begin
                    state_next = FILL_WRITE;
                end
            end
            FILL_WRITE: begin
                write_cycle = 1'b1;
                state_next  = FILL_IDLE;
            end
            default: begin
                state_next = FILL_IDLE;
            end
        endcase
    end

    assign lru_fill_set        = set_reg;
    assign l2_req_addr         = {tag_reg, set_reg};

    assign update_tag_en       = write_cycle;
    assign update_tag_way_idx  = way_reg;
    assign update_tag_set_idx  = set_reg;
    assign update_tag          = tag_reg;
    assign update_tag_valid    = write_cycle;

    assign update_data_en      = write_cycle;
    assign update_data_way_idx = way_reg;
    assign update_data_set_idx = set_reg;
    assign update_data         = line;

    assign fill_done           = write_cycle;
    assign fill_done_set_idx   = set_reg;
    assign fill_done_way_idx   = way_reg;

`ifdef CACHE_FILL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fill_count     <= '0;
            perf_l2_wait_cycles <= '0;
        end else begin
            if (write_cycle && perf_fill_count != '1) begin
                perf_fill_count <= perf_fill_count + 32'd1;
            end
            if ((state_reg == FILL_REQ || state_reg == FILL_BEAT) &&
                perf_l2_wait_cycles != '1) begin
                perf_l2_wait_cycles <= perf_l2_wait_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
